// File: rtl/simplez_sequencer_if.sv
// Micro-order bundle between the Simplez control unit and its datapath.
// The sequencer owns every micro-order; the datapath returns opcode, AC==0 and run.
interface simplez_sequencer_if;
    logic [2:0] co;
    logic       ac_zero;
    logic       run;
    logic       lec;
    logic       esc;
    logic       era;
    logic       incp;
    logic       ecp;
    logic       ccp;
    logic       scp;
    logic       sri;
    logic       eri;
    logic       eac;
    logic       sac;
    logic [1:0] alu_op;
    logic       stop;
    logic       retire;
    logic [2:0] state_o;

    modport master (
        input  co, ac_zero, run,
        output lec, esc, era, incp, ecp, ccp, scp, sri, eri, eac, sac,
               alu_op, stop, retire, state_o
    );

    modport slave (
        output co, ac_zero, run,
        input  lec, esc, era, incp, ecp, ccp, scp, sri, eri, eac, sac,
               alu_op, stop, retire, state_o
    );
endinterface

// File: rtl/simplez_sequencer.sv
// Microprogrammed control unit for the Simplez CPU: fetch, decode/execute,
// operand and termination phases, plus a run/pause gate at instruction boundaries.
//
// state  | meaning
// INI    | RA <- CP after reset
// I0     | fetch: RI <- M[RA], CP <- CP+1
// I1     | decode; short instructions execute and retire here
// O0     | operand access for ST/LD/ADD
// O1     | termination: RA <- CP, retire
// PAUSE  | idle at an instruction boundary with RA already = CP
// HALTED | stop asserted until reset
module simplez_sequencer (
    input  logic                  clk,
    input  logic                  rstn,
    simplez_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_INI    = 3'd0,
        S_I0     = 3'd1,
        S_I1     = 3'd2,
        S_O0     = 3'd3,
        S_O1     = 3'd4,
        S_PAUSE  = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_DEC  = 2'd2;
    localparam logic [1:0] ALU_ZERO = 2'd3;

    state_t state_q;
    state_t state_d;
    state_t boundary_state;

    logic       lec;
    logic       esc;
    logic       era;
    logic       incp;
    logic       ecp;
    logic       ccp;
    logic       scp;
    logic       sri;
    logic       eri;
    logic       eac;
    logic       sac;
    logic [1:0] alu_op;
    logic       stop;
    logic       retire;

    // The datapath samples on the falling edge, so the controller does too.
    always_ff @(negedge clk) begin
        if (!rstn) begin
            state_q <= S_INI;
        end else begin
            state_q <= state_d;
        end
    end

    assign boundary_state = bus.run ? S_I0 : S_PAUSE;

    always_comb begin
        state_d = state_q;
        lec     = 1'b0;
        esc     = 1'b0;
        era     = 1'b0;
        incp    = 1'b0;
        ecp     = 1'b0;
        ccp     = 1'b0;
        scp     = 1'b0;
        sri     = 1'b0;
        eri     = 1'b0;
        eac     = 1'b0;
        sac     = 1'b0;
        alu_op  = ALU_PASS;
        stop    = 1'b0;
        retire  = 1'b0;

        case (state_q)
            S_INI: begin
                scp     = 1'b1;
                era     = 1'b1;
                state_d = S_I0;
            end

            S_I0: begin
                lec     = 1'b1;
                eri     = 1'b1;
                incp    = 1'b1;
                state_d = S_I1;
            end

            S_I1: begin
                case (bus.co)
                    OP_ST, OP_LD, OP_ADD: begin
                        sri     = 1'b1;
                        era     = 1'b1;
                        state_d = S_O0;
                    end
                    OP_BR: begin
                        sri     = 1'b1;
                        ecp     = 1'b1;
                        era     = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_state;
                    end
                    OP_BZ: begin
                        // Taken branch loads CD into CP and RA; not taken re-points RA at CP.
                        if (bus.ac_zero) begin
                            sri = 1'b1;
                            ecp = 1'b1;
                        end else begin
                            scp = 1'b1;
                        end
                        era     = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_state;
                    end
                    OP_CLR: begin
                        eac     = 1'b1;
                        alu_op  = ALU_ZERO;
                        scp     = 1'b1;
                        era     = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_state;
                    end
                    OP_DEC: begin
                        eac     = 1'b1;
                        alu_op  = ALU_DEC;
                        scp     = 1'b1;
                        era     = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary_state;
                    end
                    OP_HALT: begin
                        stop    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_HALTED;
                    end
                    default: begin
                        state_d = S_INI;
                    end
                endcase
            end

            S_O0: begin
                case (bus.co)
                    OP_ST: begin
                        sac = 1'b1;
                        esc = 1'b1;
                    end
                    OP_LD: begin
                        lec    = 1'b1;
                        eac    = 1'b1;
                        alu_op = ALU_PASS;
                    end
                    OP_ADD: begin
                        lec    = 1'b1;
                        eac    = 1'b1;
                        alu_op = ALU_ADD;
                    end
                    default: begin
                    end
                endcase
                state_d = S_O1;
            end

            S_O1: begin
                scp     = 1'b1;
                era     = 1'b1;
                retire  = 1'b1;
                state_d = boundary_state;
            end

            S_PAUSE: begin
                state_d = bus.run ? S_I0 : S_PAUSE;
            end

            S_HALTED: begin
                stop    = 1'b1;
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_INI;
            end
        endcase

        // Reset wins over everything, including a write in flight.
        if (!rstn) begin
            lec    = 1'b0;
            esc    = 1'b0;
            era    = 1'b0;
            incp   = 1'b0;
            ecp    = 1'b0;
            ccp    = 1'b1;
            scp    = 1'b0;
            sri    = 1'b0;
            eri    = 1'b0;
            eac    = 1'b0;
            sac    = 1'b0;
            alu_op = ALU_PASS;
            stop   = 1'b0;
            retire = 1'b0;
        end
    end

    assign bus.lec     = lec;
    assign bus.esc     = esc;
    assign bus.era     = era;
    assign bus.incp    = incp;
    assign bus.ecp     = ecp;
    assign bus.ccp     = ccp;
    assign bus.scp     = scp;
    assign bus.sri     = sri;
    assign bus.eri     = eri;
    assign bus.eac     = eac;
    assign bus.sac     = sac;
    assign bus.alu_op  = alu_op;
    assign bus.stop    = stop;
    assign bus.retire  = retire;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_simplez_sequencer.sv
// Scoreboard bench for simplez_sequencer: each stimulus cycle queues the
// hand-derived state and micro-order word; a monitor pops and compares.
module tb_simplez_sequencer;

    logic clk;
    logic rstn;

    simplez_sequencer_if bus();

    simplez_sequencer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // micro-order word: lec esc era incp ecp ccp scp sri eri eac sac alu[1:0] stop retire
    localparam logic [14:0] LEC  = 15'h4000;
    localparam logic [14:0] ESC  = 15'h2000;
    localparam logic [14:0] ERA  = 15'h1000;
    localparam logic [14:0] INCP = 15'h0800;
    localparam logic [14:0] ECP  = 15'h0400;
    localparam logic [14:0] CCP  = 15'h0200;
    localparam logic [14:0] SCP  = 15'h0100;
    localparam logic [14:0] SRI  = 15'h0080;
    localparam logic [14:0] ERI  = 15'h0040;
    localparam logic [14:0] EAC  = 15'h0020;
    localparam logic [14:0] SAC  = 15'h0010;
    localparam logic [14:0] ALU1 = 15'h0004;
    localparam logic [14:0] ALU2 = 15'h0008;
    localparam logic [14:0] ALU3 = 15'h000C;
    localparam logic [14:0] STOP = 15'h0002;
    localparam logic [14:0] RET  = 15'h0001;

    localparam logic [2:0] ST_INI = 3'd0, ST_I0 = 3'd1, ST_I1 = 3'd2, ST_O0 = 3'd3,
                           ST_O1 = 3'd4, ST_PAUSE = 3'd5, ST_HALTED = 3'd6;
    localparam logic [2:0] OP_ST = 3'd0, OP_LD = 3'd1, OP_ADD = 3'd2, OP_BR = 3'd3,
                           OP_BZ = 3'd4, OP_CLR = 3'd5, OP_DEC = 3'd6, OP_HALT = 3'd7;

    typedef struct packed {
        logic [2:0]  st;
        logic [14:0] mo;
        logic [15:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_total;
    int   n_pass;
    int   step_idx;
    logic [14:0] act_mo;

    assign act_mo = {bus.lec, bus.esc, bus.era, bus.incp, bus.ecp, bus.ccp, bus.scp,
                     bus.sri, bus.eri, bus.eac, bus.sac, bus.alu_op, bus.stop, bus.retire};

    // One cycle: drive inputs just after the falling edge, queue what that cycle must show.
    task automatic step(input logic [2:0] co, input logic acz, input logic run_i,
                        input logic rstn_i, input logic [2:0] e_st, input logic [14:0] e_mo);
        exp_t e;
        @(negedge clk);
        #1;
        bus.co      = co;
        bus.ac_zero = acz;
        bus.run     = run_i;
        rstn        = rstn_i;
        e.st  = e_st;
        e.mo  = e_mo;
        e.idx = 16'(step_idx);
        exp_q.push_back(e);
        step_idx++;
    endtask

    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if (bus.state_o === e.st) n_pass++;
            else $display("FAIL step%0d state: got %0d expected %0d", e.idx, bus.state_o, e.st);
            n_total++;
            if (act_mo === e.mo) n_pass++;
            else $display("FAIL step%0d micro_orders: got %h expected %h", e.idx, act_mo, e.mo);
        end
    end

    initial begin
        int waited;
        n_total     = 0;
        n_pass      = 0;
        step_idx    = 0;
        rstn        = 1'b0;
        bus.co      = OP_LD;
        bus.ac_zero = 1'b0;
        bus.run     = 1'b1;
        repeat (2) @(negedge clk);

        // reset and LD: INI I0 I1 O0 O1
        step(OP_LD, 0, 1, 0, ST_INI, CCP);
        step(OP_LD, 0, 1, 1, ST_INI, SCP | ERA);
        step(OP_LD, 0, 1, 1, ST_I0,  LEC | ERI | INCP);
        step(OP_LD, 0, 1, 1, ST_I1,  SRI | ERA);
        step(OP_LD, 0, 1, 1, ST_O0,  LEC | EAC);
        step(OP_LD, 0, 1, 1, ST_O1,  SCP | ERA | RET);

        // BZ taken then not taken
        step(OP_BZ, 1, 1, 1, ST_I0,  LEC | ERI | INCP);
        step(OP_BZ, 1, 1, 1, ST_I1,  SRI | ECP | ERA | RET);
        step(OP_BZ, 0, 1, 1, ST_I0,  LEC | ERI | INCP);
        step(OP_BZ, 0, 1, 1, ST_I1,  SCP | ERA | RET);

        // BR, CLR, DEC
        step(OP_BR,  0, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_BR,  0, 1, 1, ST_I1, SRI | ECP | ERA | RET);
        step(OP_CLR, 0, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_CLR, 0, 1, 1, ST_I1, EAC | ALU3 | SCP | ERA | RET);
        step(OP_DEC, 1, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_DEC, 1, 1, 1, ST_I1, EAC | ALU2 | SCP | ERA | RET);

        // ST: write only in O0
        step(OP_ST, 0, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_ST, 0, 1, 1, ST_I1, SRI | ERA);
        step(OP_ST, 0, 1, 1, ST_O0, SAC | ESC);
        step(OP_ST, 0, 1, 1, ST_O1, SCP | ERA | RET);

        // ADD with run dropped in O0: completes, then pauses
        step(OP_ADD, 0, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_ADD, 0, 1, 1, ST_I1, SRI | ERA);
        step(OP_ADD, 0, 0, 1, ST_O0, LEC | EAC | ALU1);
        step(OP_ADD, 0, 0, 1, ST_O1, SCP | ERA | RET);
        for (int i = 0; i < 10; i++) step(OP_ADD, 0, 0, 1, ST_PAUSE, 15'h0);
        step(OP_ADD, 0, 1, 1, ST_PAUSE, 15'h0);

        // ST aborted by reset in O0, then fetch restarts from INI
        step(OP_ST, 0, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_ST, 0, 1, 1, ST_I1, SRI | ERA);
        step(OP_ST, 0, 1, 0, ST_O0, CCP);
        step(OP_ST, 0, 1, 1, ST_INI, SCP | ERA);

        // HALT, hold, then reset out of HALTED
        step(OP_HALT, 0, 1, 1, ST_I0, LEC | ERI | INCP);
        step(OP_HALT, 0, 1, 1, ST_I1, STOP | RET);
        for (int i = 0; i < 20; i++) step(OP_HALT, 0, 1, 1, ST_HALTED, STOP);
        step(OP_HALT, 0, 1, 0, ST_HALTED, CCP);
        step(OP_LD,   0, 1, 1, ST_INI, SCP | ERA);
        step(OP_LD,   0, 1, 1, ST_I0,  LEC | ERI | INCP);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simplez_sequencer.md
# simplez_sequencer

Microprogrammed control unit for the Simplez CPU. It decodes the opcode held in RI and drives every micro-order of the datapath (CP, RA, RI, AC, ALU, memory) through fetch, decode/execute, operand and termination phases for all eight instructions. It sits beside the datapath inside the `simplez` top level and replaces its partial inline state machine. It adds a run/pause gate at instruction boundaries and a retire pulse for monitoring.

## Interface
Parameters
- none. Opcode width is fixed at 3, with encodings ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.

Ports
- clk  in  1  system clock; all state updates on the falling edge, matching the datapath
- rstn  in  1  reset rstn, synchronous, active-low
- co  in  3  opcode field RI[11:9]
- ac_zero  in  1  high when AC == 0
- run  in  1  1 = execute continuously; 0 = pause at the next instruction boundary
- lec  out  1  memory read; drives busD from memory data
- esc  out  1  memory write M[RA] <- busD
- era  out  1  load RA from busAi
- incp, ecp, ccp  out  1 each  CP increment / load from busAi / clear
- scp, sri  out  1 each  drive busAi from CP / from the RI address field CD
- eri  out  1  load RI from busD
- eac, sac  out  1 each  load AC from ALU result / drive busD from AC
- alu_op  out  2  0 = pass busD, 1 = AC+busD, 2 = AC-1, 3 = zero
- stop  out  1  CPU halted
- retire  out  1  one-cycle pulse when an instruction completes
- state_o  out  3  current state, for debug and LEDs

## Operation
- States: INI=0, I0=1, I1=2, O0=3, O1=4, PAUSE=5, HALTED=6. Any other encoding goes to INI on the next edge.
- Outputs are combinational from the state, co and ac_zero (Mealy). Any micro-order not listed for a state is 0, and alu_op is 0 unless listed.
- INI: scp, era (RA <- CP). Next state I0.
- I0 (fetch): lec, eri, incp (RI <- M[RA], CP <- CP+1). Next state I1.
- I1 (decode/execute), by co:
  - ST, LD, ADD: sri, era (RA <- CD). Next state O0.
  - BR: sri, ecp, era. CP and RA both receive CD. Goes to the boundary. retire=1.
  - BZ: if ac_zero, same micro-orders as BR; otherwise scp, era. Goes to the boundary. retire=1.
  - CLR: eac, alu_op=3, scp, era. Goes to the boundary. retire=1.
  - DEC: eac, alu_op=2, scp, era. Goes to the boundary. retire=1. AC wraps 0 -> 0xFFF (12-bit modular arithmetic in the ALU).
  - HALT: stop=1. Next state HALTED. retire=1.
- O0 (operand), by co:
  - ST: sac, esc.
  - LD: lec, eac, alu_op=0.
  - ADD: lec, eac, alu_op=1 (sum modulo 2^12, no carry out).
  - Next state O1.
- O1 (termination): scp, era (RA <- CP). retire=1. Goes to the boundary.
- Boundary rule: move to I0 if run=1, otherwise to PAUSE. run is sampled on the same edge.
- PAUSE: no micro-orders. RA already holds CP. Next state I0 when run=1, otherwise stay.
- HALTED: stop=1, no other micro-orders. Stays in HALTED until rstn=0.
- ccp is asserted only while rstn=0; the datapath also clears CP on reset.

## Timing
- rstn=0 sampled at a falling edge puts the state in INI, from any state including mid-instruction or HALTED.
- While rstn=0, all outputs are forced to 0 except ccp=1, with stop=0 and retire=0. Writes in flight are aborted (esc=0).
- Cycles per instruction with run=1:
  - ST, LD, ADD: 4 (I0, I1, O0, O1).
  - BR, BZ, CLR, DEC: 2 (I0, I1).
  - HALT: 2, then HALTED.
- Memory read is synchronous: data addressed by RA at one edge is valid during the following state. That is why the fetch in I0 uses the RA loaded in INI, I1 or O1.
- retire is high for exactly one cycle per instruction. It is never asserted in INI, PAUSE or HALTED.
- A run change is seen only at a boundary. Deasserting run mid-instruction completes that instruction first.
- PAUSE is always entered with RA = CP, so resume is a plain I0 with no extra setup cycle.

## Test plan
- Reset then run=1, co=LD with memory returning 0x123: state sequence INI, I0, I1, O0, O1, I0. Check eac with alu_op=0 in O0, retire high in O1 only, and 4 cycles per LD.
- BZ with ac_zero=1 then ac_zero=0: the first asserts sri/ecp/era in I1; the second asserts scp/era with ecp=0. Both take 2 cycles and are followed by I0.
- ST: sac and esc are asserted only in O0. lec=0 throughout O0 and O1.
- HALT: stop=1 from I1 onward, state stays HALTED for 20 cycles with retire=0. Then rstn=0 for 1 cycle gives state INI, stop=0, ccp=1.
- run=0 asserted during O0 of an ADD: the ADD completes (retire in O1), then state enters PAUSE and holds 10 cycles with all micro-orders 0. run=1 gives I0 on the next edge.
- rstn=0 asserted in O0 of ST: esc drops the same cycle, the next state is INI, and the fetch restarts at CP=0.
